// File: rtl/alu_8bit_ctrl_if.sv
// Command, response and ALU-drive signals of the 8-bit ALU sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface alu_8bit_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_oper;
    logic [7:0] alu_sum;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_sum, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_oper,
               rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_sum, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_oper,
               rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_8bit_ctrl.sv
// Sequencer in front of an external 8-bit combinational ALU: single ALU ops,
// an 8x8->16 shift-add multiply through the ALU add path, and a held response.
module alu_8bit_ctrl (
    input  logic            clk,
    input  logic            rst,
    alu_8bit_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_oper_q, alu_oper_d;
    logic [7:0]  m_q, m_d;
    logic [15:0] p_q, p_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_err_q, rsp_err_d;

    logic [7:0]  alu_a_drv;
    logic [7:0]  alu_b_drv;
    logic [2:0]  alu_oper_drv;
    logic        mul_c;
    logic [15:0] p_next;

    // During MUL the ALU sees the live partial product; the registers capture it
    // every iteration so the outputs hold the last driven value after MUL ends.
    assign alu_a_drv    = (state_q == MUL) ? p_q[15:8] : alu_a_q;
    assign alu_b_drv    = (state_q == MUL) ? (p_q[0] ? m_q : 8'h00) : alu_b_q;
    assign alu_oper_drv = (state_q == MUL) ? 3'b000 : alu_oper_q;

    assign mul_c  = (bus.alu_sum < alu_a_drv);
    // The always-zero top bit of the 17-bit P is dropped; {c, sum, P[7:1]} is its lower 16 bits.
    assign p_next = {mul_c, bus.alu_sum, p_q[7:1]};

    // NOTE: every *_d gets its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_oper_d  = alu_oper_q;
        m_d         = m_q;
        p_d         = p_q;
        count_d     = count_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (!bus.cmd_op[3]) begin
                        alu_a_d    = bus.cmd_a;
                        alu_b_d    = bus.cmd_b;
                        alu_oper_d = bus.cmd_op[2:0];
                        state_d    = EXEC;
                    end else if (bus.cmd_op[2:0] == 3'b000) begin
                        m_d     = bus.cmd_a;
                        p_d     = {8'h00, bus.cmd_b};
                        count_d = 3'd0;
                        state_d = MUL;
                    end else begin
                        rsp_data_d  = 16'h0000;
                        rsp_carry_d = 1'b0;
                        rsp_zero_d  = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                end
            end

            EXEC: begin
                rsp_data_d = {8'h00, bus.alu_sum};
                rsp_zero_d = (bus.alu_sum == 8'h00);
                rsp_err_d  = 1'b0;
                case (alu_oper_q)
                    3'b000:  rsp_carry_d = (bus.alu_sum < alu_a_q);
                    3'b001:  rsp_carry_d = (alu_a_q < alu_b_q);
                    3'b010:  rsp_carry_d = (alu_b_q < alu_a_q);
                    default: rsp_carry_d = 1'b0;
                endcase
                state_d = RESP;
            end

            MUL: begin
                alu_a_d    = alu_a_drv;
                alu_b_d    = alu_b_drv;
                alu_oper_d = alu_oper_drv;
                p_d        = p_next;
                count_d    = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    rsp_data_d  = p_next;
                    rsp_carry_d = (p_next[15:8] != 8'h00);
                    rsp_zero_d  = (p_next == 16'h0000);
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_oper_q  <= 3'b000;
            m_q         <= 8'h00;
            p_q         <= 16'h0000;
            count_q     <= 3'd0;
            rsp_data_q  <= 16'h0000;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_oper_q  <= alu_oper_d;
            m_q         <= m_d;
            p_q         <= p_d;
            count_q     <= count_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.alu_a     = alu_a_drv;
    assign bus.alu_b     = alu_b_drv;
    assign bus.alu_oper  = alu_oper_drv;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_8bit_ctrl.sv
// Scoreboard bench for alu_8bit_ctrl: an ALU model closes the loop, commands push
// arithmetic-level expectations, and a negedge monitor checks every response cycle.
module tb_alu_8bit_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_8bit_ctrl_if bus ();

    alu_8bit_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Assumed ALU function table: add, a-b, b-a, or, and, xor, xnor, zero.
    function automatic logic [7:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return b - a;
            3'd3:    return a | b;
            3'd4:    return a & b;
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_sum = alu_fn(bus.alu_oper, bus.alu_a, bus.alu_b);

    typedef struct {
        int          op;
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ready_mode = 0;   // 0: ready high, 1: random, 2: held low
    bit   mon_en  = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected response computed from integer arithmetic on the operands.
    function automatic exp_t ref_model(int op, int a, int b);
        exp_t e;
        int   r;
        e.op = op; e.data = 16'h0; e.carry = 1'b0; e.err = 1'b0; e.lat = 2; e.acc_cyc = 0;
        r = 0;
        case (op)
            0: begin r = a + b; e.carry = (r > 255); r = r % 256; end
            1: begin r = (a - b + 256) % 256; e.carry = (a < b); end
            2: begin r = (b - a + 256) % 256; e.carry = (b < a); end
            3: r = a | b;
            4: r = a & b;
            5: r = a ^ b;
            6: r = 255 - (a ^ b);
            7: r = 0;
            8: begin r = a * b; e.carry = (r > 255); e.lat = 9; end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        e.data = r[15:0];
        e.zero = !e.err && (r == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, q.size() == 0});
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", {31'b0, bus.rsp_valid}, 32'd0);
                end else begin
                    if (!prev_valid)
                        check($sformatf("latency_op%0d", q[0].op), cyc - q[0].acc_cyc + 1, q[0].lat);
                    check($sformatf("rsp_data_op%0d", q[0].op), {16'b0, bus.rsp_data}, {16'b0, q[0].data});
                    check($sformatf("rsp_carry_op%0d", q[0].op), {31'b0, bus.rsp_carry}, {31'b0, q[0].carry});
                    check($sformatf("rsp_zero_op%0d", q[0].op), {31'b0, bus.rsp_zero}, {31'b0, q[0].zero});
                    check($sformatf("rsp_err_op%0d", q[0].op), {31'b0, bus.rsp_err}, {31'b0, q[0].err});
                    if (bus.rsp_ready) void'(q.pop_front());
                end
            end
            prev_valid <= bus.rsp_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                2:       bus.rsp_ready = 1'b0;
                default: bus.rsp_ready = 1'b1;
            endcase
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accept edge.
    task automatic send(int op, int a, int b);
        int   n;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'(op);
        bus.cmd_a     = 8'(a);
        bus.cmd_b     = 8'(b);
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            check("accept_timeout", {31'b0, bus.cmd_ready}, 32'd1);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            e = ref_model(op, a, b);
            e.acc_cyc = cyc;
            q.push_back(e);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_cmd_ready"}, {31'b0, bus.cmd_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({tag, "_alu_a"},     {24'b0, bus.alu_a},     32'd0);
        check({tag, "_alu_b"},     {24'b0, bus.alu_b},     32'd0);
        check({tag, "_alu_oper"},  {29'b0, bus.alu_oper},  32'd0);
        check({tag, "_rsp_data"},  {16'b0, bus.rsp_data},  32'd0);
        check({tag, "_flags"},     {29'b0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 4'd0;
        bus.cmd_a = 8'd0;
        bus.cmd_b = 8'd0;

        #3 rst = 1'b1;
        #1 check_reset_vals("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        mon_en = 1;
        @(posedge clk); #1;

        // Directed values, ready held high (back-to-back throughput).
        send(0, 200, 100);
        send(1, 5, 7);
        send(2, 5, 7);
        send(6, 8'hA5, 8'hA5);
        send(4, 8'hF0, 8'h0F);
        send(7, 8'h3C, 8'h81);
        send(8, 8'hFF, 8'hFF);
        send(8, 8'h0C, 8'h0D);
        send(8, 8'h00, 8'h37);
        send(11, 8'h12, 8'h34);
        send(15, 8'hFF, 8'hFF);
        drain();

        // Backpressure: ready low for 5 cycles with a stray command in the window.
        ready_mode = 2;
        bus.rsp_ready = 1'b0;
        send(0, 8'h10, 8'h20);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            bus.cmd_valid = (k == 1);
            bus.cmd_op    = 4'd0;
            bus.cmd_a     = 8'h55;
            bus.cmd_b     = 8'h66;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        check("bp_valid_held", {31'b0, bus.rsp_valid}, 32'd1);
        ready_mode = 0;
        bus.rsp_ready = 1'b1;
        drain();
        repeat (3) begin @(posedge clk); #1; end

        // Random commands with random response backpressure.
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        drain();
        ready_mode = 0;
        bus.rsp_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Reset in the middle of the fourth multiply iteration.
        send(8, 8'hFF, 8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        q.delete();
        #1 check_reset_vals("mid_mul");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        send(0, 3, 4);
        drain();
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_8bit_ctrl.md
# alu_8bit_ctrl

Sequencing front end for the 8-bit combinational ALU. It accepts commands over a valid/ready handshake and drives the ALU's `a`, `b` and `Oper` inputs from registers. It captures the ALU's 8-bit `sum`, derives flags, and returns a result over a second valid/ready handshake. Besides the seven native ALU operations it runs an unsigned 8×8→16 multiply, built as eight shift-add iterations through the ALU's add path.

## Interface
- No parameters; datapath width fixed at 8 bits.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept; equals (state == IDLE)
- `cmd_op`  in  4  0000–0110 = ALU Oper 000–110; 0111 = ALU zero op; 1000 = MUL; 1001–1111 illegal
- `cmd_a`, `cmd_b`  in  8 each  operands
- `alu_a`, `alu_b`  out  8 each  registered operands to ALU
- `alu_oper`  out  3  registered Oper to ALU
- `alu_sum`  in  8  ALU result (combinational from alu_a/alu_b/alu_oper)
- `rsp_valid`  out  1  result present
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  16  result; single ops zero-extended
- `rsp_carry`  out  1  carry/borrow/overflow flag
- `rsp_zero`  out  1  rsp_data == 0
- `rsp_err`  out  1  illegal opcode

## Operation
- States: IDLE, EXEC, MUL, RESP. Reset state is IDLE.
- **Reset values:** cmd_ready=1 (IDLE); alu_a=alu_b=0; alu_oper=000; rsp_valid=0; rsp_data=0; all flags 0; internal product/counter 0.
- **IDLE**
  - Accept when cmd_valid && cmd_ready.
  - Opcode 0xxx: load alu_a=cmd_a, alu_b=cmd_b, alu_oper=cmd_op[2:0]; go to EXEC.
  - Opcode 1000: load multiplicand M=cmd_a, P[16:0]={9'b0, cmd_b}, count=0; go to MUL.
  - Illegal opcode: go directly to RESP with rsp_data=0, rsp_err=1, other flags 0.
- **EXEC** (one cycle): rsp_data={8'h00, alu_sum}; go to RESP.
  - rsp_carry for Oper 000 = (alu_sum < alu_a).
  - rsp_carry for Oper 001 = (a < b), i.e. borrow.
  - rsp_carry for Oper 010 = (b < a).
  - rsp_carry = 0 for all other Oper values.
- **MUL** (eight cycles)
  - alu_oper is held at 000. alu_a = P[15:8]; alu_b = P[0] ? M : 0. These are driven combinationally from the current P, or registered one cycle ahead; either way they must be valid during the iteration cycle.
  - Per cycle: c=(alu_sum < alu_a); P ← {1'b0, c, alu_sum, P[7:1]}; count++.
  - After count reaches 7 (8th iteration): rsp_data=P[15:0], rsp_carry=(P[15:8] != 0); go to RESP.
- **RESP:** rsp_valid=1; rsp_data and flags held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and deassert rsp_valid next cycle.
- No command/response overlap: one command in flight; cmd_ready=0 in EXEC, MUL and RESP.
- rsp_zero is computed from the final rsp_data (MUL: zero iff the full 16-bit product is 0).
- Oper 111 (cmd_op 0111) is legal. The ALU returns 0, so rsp_data=0, rsp_zero=1, rsp_err=0.
- alu_* outputs hold their last value outside EXEC/MUL.
- **Reset mid-operation:** immediate return to IDLE with all reset values; no response issued for the aborted command.

## Timing
- Accept edge = cycle 0.
- Single ALU op: EXEC in cycle 1; rsp_valid high from cycle 2. Accept-to-response latency = 2.
- MUL: iterations in cycles 1–8; rsp_valid high from cycle 9. Latency = 9.
- Illegal op: rsp_valid high from cycle 1.
- With rsp_ready held high, throughput is one command per (latency+1) cycles: the response handshake cycle returns to IDLE, and cmd_ready rises on the following cycle.
- rsp_valid never drops without rsp_ready. rsp_data and flags do not change while rsp_valid && !rsp_ready.
- rsp_ready is ignored when rsp_valid=0. cmd_valid is ignored when cmd_ready=0.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle -> outputs take reset values immediately; cmd_ready=1, rsp_valid=0.
- **Add:** op 0000, a=200, b=100 -> at cycle 2 rsp_data=0x002C, rsp_carry=1, rsp_zero=0. Sub: op 0001, a=5, b=7 -> 0x00FE, carry=1. Reverse sub: op 0010, a=5, b=7 -> 0x0002, carry=0.
- **Logic ops:** op 0110, a=0xA5, b=0xA5 -> rsp_data=0x00FF. Op 0100, a=0xF0, b=0x0F -> rsp_data=0, rsp_zero=1.
- **Multiply:** op 1000, a=0xFF, b=0xFF -> rsp_valid at cycle 9 with rsp_data=0xFE01, rsp_carry=1. Also 0x0C×0x0D -> 0x009C, carry=0. Also 0×0x37 -> 0, rsp_zero=1.
- **Backpressure:** hold rsp_ready=0 for 5 cycles after rsp_valid -> data and flags stable, cmd_ready=0 throughout, and a cmd_valid pulse in this window is not accepted. Then raise rsp_ready -> cmd_ready=1 on the next cycle.
- **Illegal opcode and mid-MUL reset:** op 1011 -> rsp_valid at cycle 1 with rsp_err=1, rsp_data=0. Reset asserted during MUL cycle 4 -> no response; the next legal add completes normally.
